// File: rtl/restoring_divider_p.sv
// ----------------------------------------------------------------------------
// restoring_divider_p
// Multi-cycle restoring divider: 2*DW-bit dividend / DW-bit divisor giving a
// DW-bit quotient and remainder, with per-operation signed/unsigned mode,
// divide-by-zero and quotient-overflow detection and a start/ready/done
// handshake. One restoring step per cycle; DW+2 cycles per division.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous active-low reset
//   start      in   1     request a division (honoured only while ready=1)
//   sgn        in   1     1 = two's-complement operands, 0 = unsigned
//   dividend   in   2*DW  dividend, sampled with start
//   divisor    in   DW    divisor, sampled with start
//   ready      out  1     idle, able to accept start
//   done       out  1     one-cycle pulse, results valid
//   quotient   out  DW    quotient, held until the next result
//   remainder  out  DW    remainder, held until the next result
//   dbz        out  1     divide-by-zero flag of the last operation
//   ovf        out  1     quotient-overflow flag of the last operation
// ----------------------------------------------------------------------------
module restoring_divider_p #(
    parameter int unsigned DW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sgn,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              ready,
    output logic              done,
    output logic [DW-1:0]     quotient,
    output logic [DW-1:0]     remainder,
    output logic              dbz,
    output logic              ovf
);

    localparam int unsigned NW = 2 * DW;
    localparam int unsigned CW = $clog2(DW + 1);
    localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // State and datapath registers
    state_t          r_state,  w_state_n;
    logic [DW-1:0]   r_p,      w_p_n;      // partial remainder (always < divisor)
    logic [DW-1:0]   r_q,      w_q_n;      // quotient bits / low dividend bits
    logic [DW-1:0]   r_dvs,    w_dvs_n;    // |divisor|
    logic [CW-1:0]   r_cnt,    w_cnt_n;
    logic            r_sgn,    w_sgn_n;
    logic            r_q_neg,  w_q_neg_n;
    logic            r_r_neg,  w_r_neg_n;

    // Output registers
    logic            r_ready,  w_ready_n;
    logic            r_done,   w_done_n;
    logic [DW-1:0]   r_quot,   w_quot_n;
    logic [DW-1:0]   r_rem,    w_rem_n;
    logic            r_dbz,    w_dbz_n;
    logic            r_ovf,    w_ovf_n;

    // Operand magnitudes and early error detection at the accept edge
    logic            w_dvd_neg, w_dvs_neg;
    logic [NW-1:0]   w_dvd_mag;
    logic [DW-1:0]   w_dvs_mag;
    logic            w_dbz_c, w_ovf_c;

    assign w_dvd_neg = sgn & dividend[NW-1];
    assign w_dvs_neg = sgn & divisor[DW-1];
    // Most-negative values map onto 2^(W-1) as unsigned magnitudes
    assign w_dvd_mag = w_dvd_neg ? ((~dividend) + NW'(1)) : dividend;
    assign w_dvs_mag = w_dvs_neg ? ((~divisor) + DW'(1)) : divisor;
    assign w_dbz_c   = (divisor == '0);
    assign w_ovf_c   = !w_dbz_c && (w_dvd_mag[NW-1:DW] >= w_dvs_mag);

    // One restoring step: shift {P,Q} left, trial-subtract the divisor
    logic [DW:0]     w_p_sh;
    logic [DW-1:0]   w_trial;
    logic            w_trial_ok;

    assign w_p_sh     = {r_p, r_q[DW-1]};
    assign w_trial_ok = (w_p_sh >= {1'b0, r_dvs});
    assign w_trial    = DW'(w_p_sh - {1'b0, r_dvs});

    // Sign fix-up and late signed overflow
    logic            w_late_ovf;
    logic [DW-1:0]   w_q_fix, w_r_fix;

    assign w_late_ovf = r_sgn && (r_q_neg ? (r_q > HALF) : (r_q >= HALF));
    assign w_q_fix    = r_q_neg ? ((~r_q) + DW'(1)) : r_q;
    assign w_r_fix    = r_r_neg ? ((~r_p) + DW'(1)) : r_p;

    // Next-state and next-output logic
    always_comb begin
        w_state_n = r_state;
        w_p_n     = r_p;
        w_q_n     = r_q;
        w_dvs_n   = r_dvs;
        w_cnt_n   = r_cnt;
        w_sgn_n   = r_sgn;
        w_q_neg_n = r_q_neg;
        w_r_neg_n = r_r_neg;
        w_done_n  = 1'b0;
        w_quot_n  = r_quot;
        w_rem_n   = r_rem;
        w_dbz_n   = r_dbz;
        w_ovf_n   = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_dbz_c || w_ovf_c) begin
                        // Error decided up front: report at once, stay idle
                        w_quot_n = '1;
                        w_rem_n  = '0;
                        w_dbz_n  = w_dbz_c;
                        w_ovf_n  = w_ovf_c;
                        w_done_n = 1'b1;
                    end else begin
                        w_state_n = S_ITER;
                        w_sgn_n   = sgn;
                        w_q_neg_n = w_dvd_neg ^ w_dvs_neg;
                        w_r_neg_n = w_dvd_neg;
                        w_p_n     = w_dvd_mag[NW-1:DW];
                        w_q_n     = w_dvd_mag[DW-1:0];
                        w_dvs_n   = w_dvs_mag;
                        w_cnt_n   = CW'(DW);
                    end
                end
            end
            S_ITER: begin
                w_p_n   = w_trial_ok ? w_trial : w_p_sh[DW-1:0];
                w_q_n   = {r_q[DW-2:0], w_trial_ok};
                w_cnt_n = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_n = S_FIX;
                end
            end
            S_FIX: begin
                w_state_n = S_IDLE;
                w_done_n  = 1'b1;
                w_dbz_n   = 1'b0;
                w_ovf_n   = w_late_ovf;
                w_quot_n  = w_late_ovf ? '1 : w_q_fix;
                w_rem_n   = w_late_ovf ? '0 : w_r_fix;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_ready_n = (w_state_n == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_q     <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_sgn   <= 1'b0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_p     <= w_p_n;
            r_q     <= w_q_n;
            r_dvs   <= w_dvs_n;
            r_cnt   <= w_cnt_n;
            r_sgn   <= w_sgn_n;
            r_q_neg <= w_q_neg_n;
            r_r_neg <= w_r_neg_n;
            r_ready <= w_ready_n;
            r_done  <= w_done_n;
            r_quot  <= w_quot_n;
            r_rem   <= w_rem_n;
            r_dbz   <= w_dbz_n;
            r_ovf   <= w_ovf_n;
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_restoring_divider_p.sv
// ----------------------------------------------------------------------------
// tb_restoring_divider_p
// Directed bench for restoring_divider_p at DW=6: a table of operations with
// hand-computed results and latencies, plus sequences for start during an
// operation, reset mid-operation and back-to-back operations.
// ----------------------------------------------------------------------------
module tb_restoring_divider_p;

    localparam int unsigned DW = 6;

    logic            clk;
    logic            rst;
    logic            start;
    logic            sgn;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            ready;
    logic            done;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            dbz;
    logic            ovf;

    restoring_divider_p #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // lat = edges after the accept edge until done is observed
    typedef struct {
        logic            s;
        logic [2*DW-1:0] a;
        logic [DW-1:0]   b;
        logic [DW-1:0]   q;
        logic [DW-1:0]   r;
        logic            z;
        logic            o;
        int              lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic do_op(input vec_t v, input string tag);
        int   n;
        logic rdy0;
        @(negedge clk);
        start    = 1'b1;
        sgn      = v.s;
        dividend = v.a;
        divisor  = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        rdy0  = ready;
        n     = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(v.lat));
        chk({tag, "_ready_after_accept"}, 32'(rdy0), 32'(v.lat == 0));
        chk({tag, "_quotient"}, 32'(quotient), 32'(v.q));
        chk({tag, "_remainder"}, 32'(remainder), 32'(v.r));
        chk({tag, "_dbz"}, 32'(dbz), 32'(v.z));
        chk({tag, "_ovf"}, 32'(ovf), 32'(v.o));
        chk({tag, "_ready_in_done"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        int seen;

        //            sgn   dividend  divisor  quot   rem    dbz   ovf   lat
        vecs[0]  = '{1'b0, 12'd1000, 6'd37,  6'd27, 6'd1,  1'b0, 1'b0, 7};
        vecs[1]  = '{1'b0, 12'd1234, 6'd0,   6'h3F, 6'd0,  1'b1, 1'b0, 0};
        vecs[2]  = '{1'b0, 12'd4095, 6'd63,  6'h3F, 6'd0,  1'b0, 1'b1, 0};
        vecs[3]  = '{1'b1, 12'hF9C,  6'd7,   6'h32, 6'h3E, 1'b0, 1'b0, 7};
        vecs[4]  = '{1'b1, 12'hFE0,  6'd1,   6'h20, 6'd0,  1'b0, 1'b0, 7};
        vecs[5]  = '{1'b1, 12'd40,   6'd1,   6'h3F, 6'd0,  1'b0, 1'b1, 7};
        vecs[6]  = '{1'b0, 12'd50,   6'd7,   6'd7,  6'd1,  1'b0, 1'b0, 7};
        vecs[7]  = '{1'b1, 12'd100,  6'h39,  6'h32, 6'h02, 1'b0, 1'b0, 7};
        vecs[8]  = '{1'b1, 12'hF9C,  6'h39,  6'h0E, 6'h3E, 1'b0, 1'b0, 7};
        vecs[9]  = '{1'b1, 12'd31,   6'd1,   6'h1F, 6'd0,  1'b0, 1'b0, 7};
        vecs[10] = '{1'b1, 12'hFDF,  6'd1,   6'h3F, 6'd0,  1'b0, 1'b1, 7};
        vecs[11] = '{1'b1, 12'hF9C,  6'd0,   6'h3F, 6'd0,  1'b1, 1'b0, 0};
        vecs[12] = '{1'b1, 12'h800,  6'h20,  6'h3F, 6'd0,  1'b0, 1'b1, 0};
        vecs[13] = '{1'b0, 12'd4031, 6'd63,  6'h3F, 6'h3E, 1'b0, 1'b0, 7};

        rst      = 1'b0;
        start    = 1'b0;
        sgn      = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(dbz), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_done", 32'(done), 32'd0);

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i], $sformatf("v%0d", i));
        end

        // start pulsed during ITER is ignored
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dividend = 12'd1000; divisor = 6'd37;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 12'd5; divisor = 6'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 3;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ignore_start_latency", 32'(n), 32'd7);
        chk("ignore_start_quotient", 32'(quotient), 32'd27);
        chk("ignore_start_remainder", 32'(remainder), 32'd1);
        chk("ignore_start_dbz", 32'(dbz), 32'd0);
        @(posedge clk);
        #1;
        chk("ignore_start_no_late_error", 32'(done), 32'd0);

        // reset asserted mid-ITER clears everything at once, no done afterwards
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dividend = 12'd1000; divisor = 6'd37;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", 32'({dbz, ovf}), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        chk("abort_ready_after", 32'(ready), 32'd1);
        do_op(vecs[0], "after_abort");

        // back-to-back: second start issued in the first done cycle
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; dividend = 12'd1000; divisor = 6'd37;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'd7);
        chk("b2b_first_quotient", 32'(quotient), 32'd27);
        chk("b2b_first_remainder", 32'(remainder), 32'd1);
        start = 1'b1; dividend = 12'd50; divisor = 6'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        m = 1;
        while (!done && m < 30) begin
            @(posedge clk);
            #1;
            m++;
        end
        chk("b2b_spacing", 32'(m), 32'd8);
        chk("b2b_second_quotient", 32'(quotient), 32'd7);
        chk("b2b_second_remainder", 32'(remainder), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
